fir_mac_seq: RTL and testbench

Sequencer that sits directly upstream of the FP29i/FP16i unified ALU in the W4823 FIR datapath. It accepts one FP16 sample per handshake and shifts it into an NTAP-deep delay line. It then issues NTAP multiplies (sample × coefficient) followed by NTAP-1 serial accumulates to the ALU, tracking the ALU's fixed pipeline latency. It returns the FP29i dot product on a valid/ready output port.

---
 rtl/fir_mac_seq.sv | 215 +++++++++++++++++++++
 tb/tb_fir_mac_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq -- FIR multiply/accumulate sequencer feeding the FP29i/FP16i ALU.
//
// Each accepted FP16 sample is shifted into an NTAP-deep delay line. The
// sequencer then issues NTAP multiplies (tap[k] x coefficient k) back to back,
// collects the products as they come back from the fixed-latency ALU, and
// folds them into a running sum with NTAP-1 serial adds. The sum is presented
// on a valid/ready port. No rounding or normalisation happens here.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        sample handshake, in_data = FP16 {s, e[4:0], f[9:0]}
//   dl_clr                   zero the delay line (IDLE only, blocks acceptance)
//   coef_addr/coef_data      coefficient ROM, data arrives one cycle after addr
//   alu_a_*/alu_b_*          ALU operands (FP29i: sgn, exp[5:0], man[21:0])
//   alu_add_muln             1 = add, 0 = multiply
//   alu_y_*                  ALU result, ALU_LAT cycles after issue
//   out_valid/out_ready      result handshake, out_* = FP29i dot product
//   busy                     high whenever the sequencer is not IDLE
module fir_mac_seq #(
    parameter int NTAP    = 8,
    parameter int ALU_LAT = 4,
    parameter int CA_W    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_data,
    input  logic            dl_clr,
    output logic [CA_W-1:0] coef_addr,
    input  logic [16:0]     coef_data,
    output logic            alu_a_sgn,
    output logic [5:0]      alu_a_exp,
    output logic [21:0]     alu_a_man,
    output logic            alu_b_sgn,
    output logic [5:0]      alu_b_exp,
    output logic [21:0]     alu_b_man,
    output logic            alu_add_muln,
    input  logic            alu_y_sgn,
    input  logic [5:0]      alu_y_exp,
    input  logic [21:0]     alu_y_man,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_sgn,
    output logic [5:0]      out_exp,
    output logic [21:0]     out_man,
    output logic            busy
);

    localparam int IW = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_MWAIT, S_ACC, S_AWAIT, S_OUT
    } state_t;

    function automatic logic [28:0] pack_sample(input logic [15:0] d);
        return {d[15], 1'b0, d[14:10], 12'b0, d[9:0]};
    endfunction

    function automatic logic [28:0] pack_coef(input logic [16:0] c);
        return {c[16], 1'b0, c[15:11], 11'b0, c[10:0]};
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] i_q, i_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [15:0]   tap_q  [NTAP];
    logic [15:0]   tap_d  [NTAP];
    logic [28:0]   prod_q [NTAP];
    logic [28:0]   prod_d [NTAP];
    logic [28:0]   acc_q, acc_d;
    // Issue tracker: entry ALU_LAT-1 describes the result on alu_y_* this cycle.
    logic          trk_vld_q [ALU_LAT];
    logic          trk_vld_d [ALU_LAT];
    logic [IW-1:0] trk_idx_q [ALU_LAT];
    logic [IW-1:0] trk_idx_d [ALU_LAT];

    logic [28:0]   a_pk, b_pk, y_pk, out_pk;
    logic          cap_vld;
    logic [IW-1:0] cap_idx;

    assign y_pk    = {alu_y_sgn, alu_y_exp, alu_y_man};
    assign cap_vld = trk_vld_q[ALU_LAT-1];
    assign cap_idx = trk_idx_q[ALU_LAT-1];

    assign {alu_a_sgn, alu_a_exp, alu_a_man} = a_pk;
    assign {alu_b_sgn, alu_b_exp, alu_b_man} = b_pk;
    assign {out_sgn, out_exp, out_man}       = out_pk;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        i_d          = i_q;
        cnt_d        = cnt_q;
        tap_d        = tap_q;
        prod_d       = prod_q;
        acc_d        = acc_q;
        a_pk         = '0;
        b_pk         = '0;
        alu_add_muln = 1'b0;
        coef_addr    = '0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_pk       = '0;
        busy         = (state_q != S_IDLE);

        // Tracker shifts every cycle; only a MUL issue injects a valid entry.
        trk_vld_d[0] = 1'b0;
        trk_idx_d[0] = k_q;
        for (int j = 1; j < ALU_LAT; j++) begin
            trk_vld_d[j] = trk_vld_q[j-1];
            trk_idx_d[j] = trk_idx_q[j-1];
        end

        if (cap_vld) begin
            prod_d[cap_idx] = y_pk;
            if (cap_idx == '0) begin
                acc_d = y_pk;
            end
        end

        case (state_q)
            S_IDLE: begin
                in_ready = ~dl_clr;
                if (dl_clr) begin
                    for (int j = 0; j < NTAP; j++) tap_d[j] = '0;
                end else if (in_valid) begin
                    tap_d[0] = in_data;
                    for (int j = 1; j < NTAP; j++) tap_d[j] = tap_q[j-1];
                    k_d     = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                a_pk         = pack_sample(tap_q[k_q]);
                b_pk         = pack_coef(coef_data);
                trk_vld_d[0] = 1'b1;
                // Address runs one ahead of k so the ROM data lines up next cycle.
                if (k_q == IW'(NTAP-1)) begin
                    coef_addr = CA_W'(NTAP-1);
                    k_d       = '0;
                    state_d   = S_MWAIT;
                end else begin
                    coef_addr = CA_W'(k_q) + CA_W'(1);
                    k_d       = k_q + IW'(1);
                end
            end
            S_MWAIT: begin
                if (cap_vld && cap_idx == IW'(NTAP-1)) begin
                    i_d     = IW'(1);
                    state_d = (NTAP == 1) ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                a_pk         = acc_q;
                b_pk         = prod_q[i_q];
                alu_add_muln = 1'b1;
                cnt_d        = '0;
                state_d      = S_AWAIT;
            end
            S_AWAIT: begin
                if (cnt_q == LW'(ALU_LAT-1)) begin
                    acc_d = y_pk;
                    if (i_q == IW'(NTAP-1)) begin
                        state_d = S_OUT;
                    end else begin
                        i_d     = i_q + IW'(1);
                        state_d = S_ACC;
                    end
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_pk    = acc_q;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int j = 0; j < NTAP; j++) begin
                tap_q[j]  <= '0;
                prod_q[j] <= '0;
            end
            for (int j = 0; j < ALU_LAT; j++) begin
                trk_vld_q[j] <= 1'b0;
                trk_idx_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            i_q       <= i_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            tap_q     <= tap_d;
            prod_q    <= prod_d;
            trk_vld_q <= trk_vld_d;
            trk_idx_q <= trk_idx_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
module tb_fir_mac_seq;

    localparam int NTAP    = 8;
    localparam int ALU_LAT = 4;
    localparam int CA_W    = 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_data;
    logic            dl_clr;
    logic [CA_W-1:0] coef_addr;
    logic [16:0]     coef_data;
    logic            alu_a_sgn, alu_b_sgn, alu_y_sgn;
    logic [5:0]      alu_a_exp, alu_b_exp, alu_y_exp;
    logic [21:0]     alu_a_man, alu_b_man, alu_y_man;
    logic            alu_add_muln;
    logic            out_valid;
    logic            out_ready;
    logic            out_sgn;
    logic [5:0]      out_exp;
    logic [21:0]     out_man;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [10:0] rom_m [NTAP];
    logic [21:0] alu_pipe [ALU_LAT];

    fir_mac_seq #(.NTAP(NTAP), .ALU_LAT(ALU_LAT), .CA_W(CA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dl_clr(dl_clr),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .alu_a_sgn(alu_a_sgn), .alu_a_exp(alu_a_exp), .alu_a_man(alu_a_man),
        .alu_b_sgn(alu_b_sgn), .alu_b_exp(alu_b_exp), .alu_b_man(alu_b_man),
        .alu_add_muln(alu_add_muln),
        .alu_y_sgn(alu_y_sgn), .alu_y_exp(alu_y_exp), .alu_y_man(alu_y_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sgn(out_sgn), .out_exp(out_exp), .out_man(out_man),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM: one-cycle read latency.
    always @(posedge clk) coef_data <= {1'b0, 5'b0, rom_m[coef_addr]};

    // Behavioural ALU: mantissa-only multiply/add, ALU_LAT cycles deep.
    always @(posedge clk) begin
        alu_pipe[0] <= alu_add_muln ? (alu_a_man + alu_b_man) : (alu_a_man * alu_b_man);
        for (int j = 1; j < ALU_LAT; j++) alu_pipe[j] <= alu_pipe[j-1];
    end
    assign alu_y_sgn = 1'b0;
    assign alu_y_exp = 6'd0;
    assign alu_y_man = alu_pipe[ALU_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_rom(input int mode);
        for (int j = 0; j < NTAP; j++)
            rom_m[j] = (mode == 0) ? 11'(j + 1) : 11'(mode);
    endtask

    // One full transaction, accept at cycle 0. hold = cycles out_ready stays low.
    task automatic run_txn(input logic [9:0] f, input bit sched, input int hold,
                           input logic [21:0] exp_man, input logic [10:0] c0);
        @(negedge clk);
        chk("in_ready_c0", 32'(in_ready), 32'd1);
        if (sched) chk("coef_addr_c0", 32'(coef_addr), 32'd0);
        in_valid = 1'b1;
        in_data  = {1'b0, 5'd0, f};
        for (int c = 1; c < 48; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 1) begin
                chk("mul0_a", 32'(alu_a_man), 32'(f));
                chk("mul0_b", 32'(alu_b_man), 32'(c0));
            end
            if (sched) begin
                if (c <= 8) chk("coef_addr", 32'(coef_addr), (c < 8) ? 32'(c) : 32'd7);
                chk("add_muln", 32'(alu_add_muln),
                    (c >= 13 && c <= 43 && (c - 13) % 5 == 0) ? 32'd1 : 32'd0);
                chk("busy", 32'(busy), 32'd1);
                chk("in_ready_busy", 32'(in_ready), 32'd0);
            end
            if (c == 47) chk("out_valid_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("out_valid_c48", 32'(out_valid), 32'd1);
        chk("out_man", 32'(out_man), 32'(exp_man));
        chk("out_sgn_exp", 32'({out_sgn, out_exp}), 32'd0);
        if (hold == 0) out_ready = 1'b1;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_man", 32'(out_man), 32'(exp_man));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (h == hold) out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        dl_clr    = 1'b0;
        out_ready = 1'b0;
        set_rom(2);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_coef_addr", 32'(coef_addr), 32'd0);
        chk("rst_alu", 32'({alu_add_muln, alu_a_man, alu_b_man} != 0), 32'd0);
        rst_n = 1'b1;

        // Single sample, coefficients all 2: only tap[0] is non-zero.
        run_txn(10'd3, 1'b0, 0, 22'd6, 11'd2);

        // Clear taps, then four samples against coefficients k+1.
        @(negedge clk);
        dl_clr = 1'b1;
        @(negedge clk);
        dl_clr = 1'b0;
        set_rom(0);
        run_txn(10'd1, 1'b1, 0,  22'd1,  11'd1);
        run_txn(10'd2, 1'b0, 0,  22'd4,  11'd1);
        run_txn(10'd3, 1'b0, 0,  22'd10, 11'd1);
        run_txn(10'd4, 1'b0, 10, 22'd20, 11'd1);

        // dl_clr together with in_valid: no accept, taps zeroed.
        set_rom(1);
        @(negedge clk);
        dl_clr   = 1'b1;
        in_valid = 1'b1;
        in_data  = {1'b0, 5'd0, 10'd9};
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        dl_clr   = 1'b0;
        in_valid = 1'b0;
        chk("clr_not_accepted", 32'(busy), 32'd0);
        run_txn(10'd5, 1'b0, 0, 22'd5, 11'd1);

        // Reset in the middle of an AWAIT phase.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {1'b0, 5'd0, 10'd7};
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out", 32'({out_valid, out_sgn, out_exp, out_man} != 0), 32'd0);
        chk("mid_rst_alu", 32'({alu_add_muln, alu_a_sgn, alu_a_exp, alu_a_man,
                                alu_b_sgn, alu_b_exp, alu_b_man} != 0), 32'd0);
        chk("mid_rst_coef_addr", 32'(coef_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(10'd6, 1'b0, 0, 22'd6, 11'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
